// File: rtl/phase_shifter_nch_if.sv
// Bundle for the phase shifter: raw keys, step-size switch and realign pulse going in,
// per-channel square waves and step status coming out.
interface phase_shifter_nch_if #(
   parameter int N_CH  = 2,
   parameter int ACC_W = 16
);

   logic [2*N_CH-1:0]     key_ctl;
   logic                  sw_ctl;
   logic                  sync_req;
   logic [N_CH-1:0]       mod;
   logic [N_CH-1:0]       pending;
   logic [N_CH-1:0]       drop;
   logic [N_CH*ACC_W-1:0] phase_acc;

   modport master (
      output key_ctl,
      output sw_ctl,
      output sync_req,
      input  mod,
      input  pending,
      input  drop,
      input  phase_acc
   );

   modport slave (
      input  key_ctl,
      input  sw_ctl,
      input  sync_req,
      output mod,
      output pending,
      output drop,
      output phase_acc
   );

endinterface

// File: rtl/phase_shifter_nch.sv
// N-channel 50%-duty square-wave generator; a key press stretches or shrinks exactly one
// half-period of its channel, shifting that channel's phase against the others.
module phase_shifter_nch #(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 16,
   parameter int HALF_PERIOD = 4999,
   parameter int FINE_STEP   = 1,
   parameter int COARSE_STEP = 50,
   parameter int ACC_W       = 16
) (
   input logic               clk,
   input logic               rst,
   phase_shifter_nch_if.slave bus
);

   // Signed working width wide enough for counter terms and accumulator sums alike.
   localparam int SW = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 2;

   localparam logic [CNT_W-1:0]     HP_TERM  = CNT_W'(HALF_PERIOD);
   localparam logic signed [SW-1:0] HP_W     = SW'(HALF_PERIOD);
   localparam logic signed [SW-1:0] FINE_W   = SW'(FINE_STEP);
   localparam logic signed [SW-1:0] COARSE_W = SW'(COARSE_STEP);
   localparam logic signed [SW-1:0] ACC_MAX  = SW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SW-1:0] ACC_MIN  = -(SW'(2 ** (ACC_W - 1)));

   logic [1:0]              sync1_q [N_CH];
   logic [1:0]              sync2_q [N_CH];
   logic [1:0]              prev_q  [N_CH];
   logic [1:0]              hold_q  [N_CH];
   logic [CNT_W-1:0]        cnt_q   [N_CH];
   logic [CNT_W-1:0]        term_q  [N_CH];
   logic signed [SW-1:0]    delta_q [N_CH];
   logic signed [ACC_W-1:0] acc_q   [N_CH];
   logic [N_CH-1:0]         mod_q;
   logic [N_CH-1:0]         pend_q;
   logic [N_CH-1:0]         drop_q;

   logic [1:0]              press     [N_CH];
   logic [N_CH-1:0]         accept;
   logic [N_CH-1:0]         discard;
   logic [N_CH-1:0]         at_term;
   logic signed [SW-1:0]    new_delta [N_CH];
   logic signed [SW-1:0]    acc_sum   [N_CH];
   logic [CNT_W-1:0]        step_term [N_CH];
   logic signed [ACC_W-1:0] acc_sat   [N_CH];
   logic signed [SW-1:0]    step_mag;
   logic [N_CH*ACC_W-1:0]   acc_flat;

   assign step_mag = bus.sw_ctl ? COARSE_W : FINE_W;

   // A simultaneous left+right press cancels out; a lone press while a step is still
   // waiting for its boundary is thrown away and remembered in the sticky drop flag.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         press[c]     = prev_q[c] & ~sync2_q[c] & ~hold_q[c];
         accept[c]    = (press[c][0] ^ press[c][1]) & ~pend_q[c];
         discard[c]   = (press[c][0] ^ press[c][1]) & pend_q[c];
         at_term[c]   = (cnt_q[c] == term_q[c]);
         new_delta[c] = press[c][1] ? step_mag : -step_mag;
         step_term[c] = CNT_W'(HP_W + delta_q[c]);
         acc_sum[c]   = SW'(acc_q[c]) + delta_q[c];
         if (acc_sum[c] > ACC_MAX) begin
            acc_sat[c] = ACC_MAX[ACC_W-1:0];
         end else if (acc_sum[c] < ACC_MIN) begin
            acc_sat[c] = ACC_MIN[ACC_W-1:0];
         end else begin
            acc_sat[c] = acc_sum[c][ACC_W-1:0];
         end
      end
   end

   // Latched steps only ever take effect at a half-period boundary, so the stretched or
   // shortened terminal count is loaded for exactly the half-period that follows.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < N_CH; c++) begin
            sync1_q[c] <= 2'b11;
            sync2_q[c] <= 2'b11;
            prev_q[c]  <= 2'b11;
            hold_q[c]  <= 2'b00;
            cnt_q[c]   <= '0;
            term_q[c]  <= HP_TERM;
            delta_q[c] <= '0;
            acc_q[c]   <= '0;
         end
         mod_q  <= '0;
         pend_q <= '0;
         drop_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            sync1_q[c] <= bus.key_ctl[2*c +: 2];
            sync2_q[c] <= sync1_q[c];
            prev_q[c]  <= sync2_q[c];
            hold_q[c]  <= (hold_q[c] | (accept[c] ? press[c] : 2'b00)) & ~sync2_q[c];
            if (bus.sync_req) begin
               cnt_q[c]  <= '0;
               term_q[c] <= HP_TERM;
               acc_q[c]  <= '0;
               mod_q[c]  <= 1'b0;
               pend_q[c] <= 1'b0;
               drop_q[c] <= 1'b0;
            end else begin
               if (at_term[c]) begin
                  cnt_q[c]  <= '0;
                  mod_q[c]  <= ~mod_q[c];
                  term_q[c] <= pend_q[c] ? step_term[c] : HP_TERM;
                  if (pend_q[c]) begin
                     acc_q[c] <= acc_sat[c];
                  end
               end else begin
                  cnt_q[c] <= cnt_q[c] + CNT_W'(1);
               end
               pend_q[c] <= accept[c] | (pend_q[c] & ~at_term[c]);
               if (accept[c]) begin
                  delta_q[c] <= new_delta[c];
               end
               if (discard[c]) begin
                  drop_q[c] <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      acc_flat = '0;
      for (int c = 0; c < N_CH; c++) begin
         acc_flat[c*ACC_W +: ACC_W] = acc_q[c];
      end
   end

   assign bus.mod       = mod_q;
   assign bus.pending   = pend_q;
   assign bus.drop      = drop_q;
   assign bus.phase_acc = acc_flat;

endmodule

// File: tb/tb_phase_shifter_nch.sv
// Bench for phase_shifter_nch: a cycle-level reference model predicts every output change,
// and a negedge monitor consumes those predictions as the DUT's outputs move.
module tb_phase_shifter_nch;

   localparam int N_CH        = 2;
   localparam int CNT_W       = 16;
   localparam int HALF_PERIOD = 39;
   localparam int FINE_STEP   = 1;
   localparam int COARSE_STEP = 7;
   localparam int ACC_W       = 6;
   localparam int HALF        = HALF_PERIOD + 1;
   localparam int ACC_HI      = (2 ** (ACC_W - 1)) - 1;
   localparam int ACC_LO      = -(2 ** (ACC_W - 1));

   typedef struct {
      int cyc;
      int ch;
      bit mod;
      bit pend;
      bit drp;
      int acc;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;
   ev_t  exp_q[$];

   int              m_pos   [N_CH];
   int              m_len   [N_CH];
   int              m_delta [N_CH];
   int              m_acc   [N_CH];
   bit              m_mod   [N_CH];
   bit              m_pend  [N_CH];
   bit              m_drop  [N_CH];
   logic [2*N_CH-1:0] k1, k2, k3;

   phase_shifter_nch_if #(.N_CH(N_CH), .ACC_W(ACC_W)) bus ();

   phase_shifter_nch #(
      .N_CH(N_CH), .CNT_W(CNT_W), .HALF_PERIOD(HALF_PERIOD),
      .FINE_STEP(FINE_STEP), .COARSE_STEP(COARSE_STEP), .ACC_W(ACC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      if (v > ACC_HI) return ACC_HI;
      if (v < ACC_LO) return ACC_LO;
      return v;
   endfunction

   function automatic void push_ev(input int c);
      ev_t e;
      e.cyc  = cyc;
      e.ch   = c;
      e.mod  = m_mod[c];
      e.pend = m_pend[c];
      e.drp  = m_drop[c];
      e.acc  = m_acc[c];
      exp_q.push_back(e);
   endfunction

   // Reference model: a press is a key bit seen high three edges ago and low two edges ago;
   // each half-period lasts HALF cycles unless a latched step stretches the next one.
   always @(posedge clk) begin : model
      bit o_mod, o_pend, o_drop, pl, pr, term, took;
      int o_acc, step;
      cyc++;
      for (int c = 0; c < N_CH; c++) begin
         o_mod  = m_mod[c];
         o_pend = m_pend[c];
         o_drop = m_drop[c];
         o_acc  = m_acc[c];
         if (!rst || bus.sync_req) begin
            m_pos[c]  = 0;
            m_len[c]  = HALF;
            m_mod[c]  = 1'b0;
            m_pend[c] = 1'b0;
            m_drop[c] = 1'b0;
            m_acc[c]  = 0;
         end else begin
            pl   = k3[2*c] && !k2[2*c];
            pr   = k3[2*c+1] && !k2[2*c+1];
            term = (m_pos[c] == m_len[c] - 1);
            took = 1'b0;
            if (term) begin
               m_mod[c] = !m_mod[c];
               m_pos[c] = 0;
               if (o_pend) begin
                  m_len[c] = HALF + m_delta[c];
                  m_acc[c] = sat(m_acc[c] + m_delta[c]);
               end else begin
                  m_len[c] = HALF;
               end
            end else begin
               m_pos[c]++;
            end
            if (pl != pr) begin
               if (o_pend) begin
                  m_drop[c] = 1'b1;
               end else begin
                  step       = bus.sw_ctl ? COARSE_STEP : FINE_STEP;
                  m_delta[c] = pr ? step : -step;
                  took       = 1'b1;
               end
            end
            m_pend[c] = took || (o_pend && !term);
         end
         if (mon_en && (o_mod != m_mod[c] || o_pend != m_pend[c] ||
                        o_drop != m_drop[c] || o_acc != m_acc[c])) begin
            push_ev(c);
         end
      end
      if (!rst) begin
         k1 = '1;
         k2 = '1;
         k3 = '1;
      end else begin
         k3 = k2;
         k2 = k1;
         k1 = bus.key_ctl;
      end
   end

   // Monitor: every change on a channel's outputs must match the next predicted event.
   always @(negedge clk) begin : monitor
      logic [N_CH-1:0] p_mod, p_pend, p_drop;
      int   p_acc [N_CH];
      bit   d_mod, d_pend, d_drop;
      int   d_acc;
      ev_t  e;
      for (int c = 0; c < N_CH; c++) begin
         d_mod  = bus.mod[c];
         d_pend = bus.pending[c];
         d_drop = bus.drop[c];
         d_acc  = $signed(bus.phase_acc[c*ACC_W +: ACC_W]);
         if (mon_en && (d_mod != p_mod[c] || d_pend != p_pend[c] ||
                        d_drop != p_drop[c] || d_acc != p_acc[c])) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_change ch%0d cyc=%0d got mod=%0b pend=%0b drop=%0b acc=%0d, expected no change",
                        c, cyc, d_mod, d_pend, d_drop, d_acc);
            end else begin
               e = exp_q.pop_front();
               if (e.ch != c || e.cyc != cyc || e.mod != d_mod || e.pend != d_pend ||
                   e.drp != d_drop || e.acc != d_acc) begin
                  failures++;
                  $display("[TB] FAIL event ch%0d got cyc=%0d mod=%0b pend=%0b drop=%0b acc=%0d, expected ch%0d cyc=%0d mod=%0b pend=%0b drop=%0b acc=%0d",
                           c, cyc, d_mod, d_pend, d_drop, d_acc,
                           e.ch, e.cyc, e.mod, e.pend, e.drp, e.acc);
               end
            end
         end
         p_mod[c]  = d_mod;
         p_pend[c] = d_pend;
         p_drop[c] = d_drop;
         p_acc[c]  = d_acc;
      end
      while (mon_en && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL missing_change ch%0d at cyc=%0d, expected mod=%0b pend=%0b drop=%0b acc=%0d, DUT unchanged",
                  e.ch, e.cyc, e.mod, e.pend, e.drp, e.acc);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_val(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int c = 0; c < N_CH; c++) begin
         check_val($sformatf("%s_mod%0d", tag, c), int'(bus.mod[c]), 0);
         check_val($sformatf("%s_pend%0d", tag, c), int'(bus.pending[c]), 0);
         check_val($sformatf("%s_acc%0d", tag, c), $signed(bus.phase_acc[c*ACC_W +: ACC_W]), 0);
      end
   endtask

   task automatic check_output();
      for (int c = 0; c < N_CH; c++) begin
         check_val($sformatf("final_state%0d", c),
                   {bus.mod[c], bus.pending[c], bus.drop[c]} * 1000 + $signed(bus.phase_acc[c*ACC_W +: ACC_W]),
                   {m_mod[c], m_pend[c], m_drop[c]} * 1000 + m_acc[c]);
      end
   endtask

   task automatic press_key(input int bitn, input int hold, input bit coarse);
      bus.sw_ctl       = coarse;
      bus.key_ctl[bitn] = 1'b0;
      idle(hold);
      bus.key_ctl[bitn] = 1'b1;
   endtask

   task automatic sync_pulse();
      bus.sync_req = 1'b1;
      @(negedge clk);
      bus.sync_req = 1'b0;
   endtask

   task automatic wait_pos(input int ch, input int p);
      for (int i = 0; i < 200; i++) begin
         if (m_pos[ch] == p) return;
         @(negedge clk);
      end
      checks++;
      failures++;
      $display("[TB] FAIL wait_pos ch%0d got no pos=%0d within 200 cycles, expected it", ch, p);
   endtask

   task automatic apply_stimulus(input int kind);
      int ch;
      case (kind)
         0: press_key($urandom_range(0, 2*N_CH-1), $urandom_range(1, 25), 1'($urandom_range(0, 1)));
         1: begin
            ch = $urandom_range(0, N_CH-1);
            bus.key_ctl[2*ch +: 2] = 2'b00;
            idle($urandom_range(1, 10));
            bus.key_ctl[2*ch +: 2] = 2'b11;
         end
         2: sync_pulse();
         3: begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
         default: idle(1);
      endcase
   endtask

   initial begin
      int r;
      rst          = 1'b0;
      bus.key_ctl  = '1;
      bus.sw_ctl   = 1'b0;
      bus.sync_req = 1'b0;
      idle(3);
      check_val("reset_drop", int'(bus.drop), 0);
      check_zero("reset");
      rst    = 1'b1;
      mon_en = 1'b1;

      idle(100);

      press_key(1, 20, 1'b0);
      idle(120);
      check_val("fine_right_acc0", $signed(bus.phase_acc[0 +: ACC_W]), 1);
      check_val("fine_right_acc1", $signed(bus.phase_acc[ACC_W +: ACC_W]), 0);

      press_key(2, 5, 1'b1);
      idle(120);
      check_val("coarse_left_acc1", $signed(bus.phase_acc[ACC_W +: ACC_W]), -COARSE_STEP);

      press_key(1, 300, 1'b0);
      idle(60);
      check_val("held_key_acc0", $signed(bus.phase_acc[0 +: ACC_W]), 2);
      wait_pos(0, 5);
      press_key(1, 3, 1'b0);
      idle(2);
      press_key(1, 3, 1'b0);
      idle(100);
      check_val("double_press_acc0", $signed(bus.phase_acc[0 +: ACC_W]), 3);
      check_val("double_press_drop0", int'(bus.drop[0]), 1);

      sync_pulse();
      idle(5);
      bus.key_ctl[1:0] = 2'b00;
      idle(10);
      bus.key_ctl[1:0] = 2'b11;
      idle(5);
      check_val("both_keys_pend0", int'(bus.pending[0]), 0);
      check_val("both_keys_drop0", int'(bus.drop[0]), 0);

      wait_pos(1, 2);
      press_key(3, 3, 1'b1);
      idle(2);
      check_val("pre_sync_pend1", int'(bus.pending[1]), 1);
      sync_pulse();
      check_zero("sync");
      wait_pos(0, 2);
      press_key(0, 3, 1'b0);
      idle(2);
      check_val("pre_rst_pend0", int'(bus.pending[0]), 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_zero("midrst");

      for (int i = 0; i < 8; i++) begin
         press_key(1, 3, 1'b1);
         idle(90);
      end
      check_val("sat_high_acc0", $signed(bus.phase_acc[0 +: ACC_W]), ACC_HI);
      for (int i = 0; i < 10; i++) begin
         press_key(0, 3, 1'b1);
         idle(90);
      end
      check_val("sat_low_acc0", $signed(bus.phase_acc[0 +: ACC_W]), ACC_LO);

      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 19);
         if (r < 12)       apply_stimulus(0);
         else if (r < 15)  apply_stimulus(1);
         else if (r < 17)  apply_stimulus(2);
         else if (r == 17) apply_stimulus(3);
         else              apply_stimulus(4);
         idle($urandom_range(0, 60));
      end

      idle(200);
      check_output();
      check_val("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
